// File: rtl/ff_bank_pkg.sv
// Shared encodings for the flip-flop bank: channel modes and SR-conflict policies.
package ff_bank_pkg;

   typedef enum logic [1:0] {
      MODE_D  = 2'd0,
      MODE_T  = 2'd1,
      MODE_JK = 2'd2,
      MODE_SR = 2'd3
   } ff_mode_t;

   typedef enum logic [1:0] {
      SRC_ZERO = 2'd0,
      SRC_RST  = 2'd1,
      SRC_SET  = 2'd2,
      SRC_HOLD = 2'd3
   } sr_policy_t;

endpackage

// File: rtl/ff_cell.sv
// One flip-flop channel: run-time mode register, q/q_bar pair, sticky SR-conflict flag
// and a one-cycle change pulse.
module ff_cell
   import ff_bank_pkg::*;
#(
   parameter logic [1:0] DEFAULT_MODE = 2'd3,
   parameter logic [1:0] SR_CONFLICT  = 2'd0,
   parameter logic       RESET_Q      = 1'b0
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       en,
   input  logic       in_a,
   input  logic       in_b,
   input  logic       mode_we,
   input  logic [1:0] mode_wdata,
   input  logic       err_clr,
   output logic       q,
   output logic       q_bar,
   output logic [1:0] mode,
   output logic       err_sticky,
   output logic       chg
);

   localparam sr_policy_t POLICY = sr_policy_t'(SR_CONFLICT);

   ff_mode_t mode_r;
   logic     q_nx;
   logic     q_bar_nx;
   logic     wr;
   logic     conflict;

   assign mode = mode_r;

   // Next-state: wr marks a non-hold update, which always rewrites q_bar as ~q_nx.
   // The SRC_ZERO conflict is the one case that drives both outputs low directly.
   always_comb begin
      q_nx     = q;
      q_bar_nx = q_bar;
      wr       = 1'b0;
      conflict = 1'b0;
      if (en) begin
         unique case (mode_r)
            MODE_D: begin
               wr   = 1'b1;
               q_nx = in_a;
            end
            MODE_T: begin
               if (in_a) begin
                  wr   = 1'b1;
                  q_nx = ~q;
               end
            end
            MODE_JK: begin
               case ({in_a, in_b})
                  2'b01:   begin wr = 1'b1; q_nx = 1'b0; end
                  2'b10:   begin wr = 1'b1; q_nx = 1'b1; end
                  2'b11:   begin wr = 1'b1; q_nx = ~q;   end
                  default: ;
               endcase
            end
            MODE_SR: begin
               case ({in_a, in_b})
                  2'b01:   begin wr = 1'b1; q_nx = 1'b0; end
                  2'b10:   begin wr = 1'b1; q_nx = 1'b1; end
                  2'b11: begin
                     conflict = 1'b1;
                     unique case (POLICY)
                        SRC_ZERO: begin q_nx = 1'b0; q_bar_nx = 1'b0; end
                        SRC_RST:  begin wr = 1'b1; q_nx = 1'b0; end
                        SRC_SET:  begin wr = 1'b1; q_nx = 1'b1; end
                        SRC_HOLD: ;
                     endcase
                  end
                  default: ;
               endcase
            end
         endcase
         if (wr) begin
            q_bar_nx = ~q_nx;
         end
      end
   end

   // State registers; a mode write lands after this edge's data update has used the old mode.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         q          <= RESET_Q;
         q_bar      <= ~RESET_Q;
         mode_r     <= ff_mode_t'(DEFAULT_MODE);
         err_sticky <= 1'b0;
         chg        <= 1'b0;
      end else begin
         q          <= q_nx;
         q_bar      <= q_bar_nx;
         chg        <= q_nx ^ q;
         err_sticky <= conflict | (err_sticky & ~err_clr);
         if (mode_we) begin
            mode_r <= ff_mode_t'(mode_wdata);
         end
      end
   end

endmodule

// File: rtl/ff_bank.sv
// Bank of WIDTH independent flip-flop channels with per-channel run-time modes.
module ff_bank
   import ff_bank_pkg::*;
#(
   parameter int unsigned WIDTH        = 8,
   parameter logic [1:0]  DEFAULT_MODE = 2'd3,
   parameter logic [1:0]  SR_CONFLICT  = 2'd0,
   parameter logic        RESET_Q      = 1'b0,
   localparam int unsigned CH_W        = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [WIDTH-1:0]     en,
   input  logic [WIDTH-1:0]     in_a,
   input  logic [WIDTH-1:0]     in_b,
   input  logic                 cfg_we,
   input  logic [CH_W-1:0]      cfg_ch,
   input  logic [1:0]           cfg_mode,
   input  logic [WIDTH-1:0]     err_clr,
   output logic [WIDTH-1:0]     q,
   output logic [WIDTH-1:0]     q_bar,
   output logic [2*WIDTH-1:0]   mode,
   output logic [WIDTH-1:0]     err_sticky,
   output logic [WIDTH-1:0]     chg
);

   logic [WIDTH-1:0] mode_we;

   // One-hot mode-write strobes; an out-of-range cfg_ch matches no channel and is dropped.
   always_comb begin
      mode_we = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         if (cfg_we && (cfg_ch == CH_W'(i))) begin
            mode_we[i] = 1'b1;
         end
      end
   end

   for (genvar g = 0; g < WIDTH; g++) begin : g_cell
      ff_cell #(
         .DEFAULT_MODE (DEFAULT_MODE),
         .SR_CONFLICT  (SR_CONFLICT),
         .RESET_Q      (RESET_Q)
      ) u_cell (
         .clk        (clk),
         .reset_n    (reset_n),
         .en         (en[g]),
         .in_a       (in_a[g]),
         .in_b       (in_b[g]),
         .mode_we    (mode_we[g]),
         .mode_wdata (cfg_mode),
         .err_clr    (err_clr[g]),
         .q          (q[g]),
         .q_bar      (q_bar[g]),
         .mode       (mode[2*g +: 2]),
         .err_sticky (err_sticky[g]),
         .chg        (chg[g])
      );
   end

endmodule

// File: tb/tb_ff_bank.sv
// Bench for ff_bank: four 8-channel instances (one per SR-conflict policy) and a
// 6-channel instance for out-of-range mode writes, all checked against a channel model.
module tb_ff_bank;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [7:0] en, in_a, in_b, err_clr;
   logic       cfg_we;
   logic [2:0] cfg_ch;
   logic [1:0] cfg_mode;

   logic [7:0]  q_o[5], qb_o[5], err_o[5], chg_o[5];
   logic [15:0] mode_o[5];
   logic [5:0]  nq, nqb, nerr, nchg;
   logic [11:0] nmode;

   int n_cmp = 0;
   int n_bad = 0;

   // Model state: [instance][channel]
   bit       mq[5][8], mqb[5][8], merr[5][8], mchg[5][8];
   bit [1:0] mmode[5][8];

   always #5 clk = ~clk;

   for (genvar p = 0; p < 4; p++) begin : g_dut
      ff_bank #(
         .WIDTH        (8),
         .DEFAULT_MODE (2'd3),
         .SR_CONFLICT  (2'(p)),
         .RESET_Q      (1'b0)
      ) u_dut (
         .clk        (clk),
         .reset_n    (reset_n),
         .en         (en),
         .in_a       (in_a),
         .in_b       (in_b),
         .cfg_we     (cfg_we),
         .cfg_ch     (cfg_ch),
         .cfg_mode   (cfg_mode),
         .err_clr    (err_clr),
         .q          (q_o[p]),
         .q_bar      (qb_o[p]),
         .mode       (mode_o[p]),
         .err_sticky (err_o[p]),
         .chg        (chg_o[p])
      );
   end

   ff_bank #(
      .WIDTH        (6),
      .DEFAULT_MODE (2'd3),
      .SR_CONFLICT  (2'd0),
      .RESET_Q      (1'b0)
   ) u_narrow (
      .clk        (clk),
      .reset_n    (reset_n),
      .en         (en[5:0]),
      .in_a       (in_a[5:0]),
      .in_b       (in_b[5:0]),
      .cfg_we     (cfg_we),
      .cfg_ch     (cfg_ch),
      .cfg_mode   (cfg_mode),
      .err_clr    (err_clr[5:0]),
      .q          (nq),
      .q_bar      (nqb),
      .mode       (nmode),
      .err_sticky (nerr),
      .chg        (nchg)
   );

   assign q_o[4]    = {2'b00, nq};
   assign qb_o[4]   = {2'b00, nqb};
   assign err_o[4]  = {2'b00, nerr};
   assign chg_o[4]  = {2'b00, nchg};
   assign mode_o[4] = {4'h0, nmode};

   function automatic int wid(int k);
      return (k == 4) ? 6 : 8;
   endfunction

   function automatic int pol(int k);
      return (k == 4) ? 0 : k;
   endfunction

   // Model: each enabled channel resolves to an action; mode writes apply after data.
   task automatic model_edge();
      int kind;   // 0 hold, 1 clear, 2 set, 3 toggle, 4 both outputs low
      bit a, b, conf, nq_m, nqb_m, old;
      for (int k = 0; k < 5; k++) begin
         for (int i = 0; i < wid(k); i++) begin
            if (!reset_n) begin
               mq[k][i] = 0; mqb[k][i] = 1; mmode[k][i] = 2'd3;
               merr[k][i] = 0; mchg[k][i] = 0;
            end else begin
               a = in_a[i]; b = in_b[i]; conf = 0; kind = 0;
               if (en[i]) begin
                  case (mmode[k][i])
                     2'd0: kind = a ? 2 : 1;
                     2'd1: kind = a ? 3 : 0;
                     2'd2: kind = (a && b) ? 3 : a ? 2 : b ? 1 : 0;
                     default: begin
                        if (a && b) begin
                           conf = 1;
                           kind = (pol(k) == 0) ? 4 : (pol(k) == 1) ? 1 : (pol(k) == 2) ? 2 : 0;
                        end else begin
                           kind = a ? 2 : b ? 1 : 0;
                        end
                     end
                  endcase
               end
               old = mq[k][i]; nq_m = old; nqb_m = mqb[k][i];
               case (kind)
                  1: begin nq_m = 0;    nqb_m = 1;    end
                  2: begin nq_m = 1;    nqb_m = 0;    end
                  3: begin nq_m = !old; nqb_m = old;  end
                  4: begin nq_m = 0;    nqb_m = 0;    end
                  default: ;
               endcase
               mq[k][i] = nq_m; mqb[k][i] = nqb_m;
               mchg[k][i] = (nq_m != old);
               merr[k][i] = conf || (merr[k][i] && !err_clr[i]);
            end
         end
         if (reset_n && cfg_we && (int'(cfg_ch) < wid(k))) mmode[k][cfg_ch] = cfg_mode;
      end
   endtask

   function automatic logic [47:0] exp_vec(int k);
      logic [7:0] q, qb, e, c;
      logic [15:0] md;
      q = '0; qb = '0; e = '0; c = '0; md = '0;
      for (int i = 0; i < wid(k); i++) begin
         q[i] = mq[k][i]; qb[i] = mqb[k][i]; e[i] = merr[k][i]; c[i] = mchg[k][i];
         md[2*i +: 2] = mmode[k][i];
      end
      return {md, e, c, qb, q};
   endfunction

   function automatic logic [47:0] act_vec(int k);
      return {mode_o[k], err_o[k], chg_o[k], qb_o[k], q_o[k]};
   endfunction

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle();
      en = '0; in_a = '0; in_b = '0; err_clr = '0;
      cfg_we = 1'b0; cfg_ch = '0; cfg_mode = '0;
   endtask

   task automatic rand_inputs();
      en = 8'($urandom); in_a = 8'($urandom); in_b = 8'($urandom);
      err_clr = 8'($urandom); cfg_we = 1'($urandom);
      cfg_ch = 3'($urandom); cfg_mode = 2'($urandom);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (2) begin
         rand_inputs();
         tick();
      end
      for (int k = 0; k < 5; k++) begin
         n_cmp++;
         if (act_vec(k) !== exp_vec(k)) begin
            n_bad++; $display("FAIL reset_state inst%0d got %h exp %h", k, act_vec(k), exp_vec(k));
         end
         n_cmp++;
         if ({q_o[k], qb_o[k], err_o[k], chg_o[k]} !== {8'h00, (k == 4) ? 8'h3F : 8'hFF, 16'h0000}) begin
            n_bad++; $display("FAIL reset_values inst%0d got q=%h qb=%h err=%h chg=%h", k, q_o[k], qb_o[k], err_o[k], chg_o[k]);
         end
         n_cmp++;
         if (mode_o[k] !== ((k == 4) ? 16'h0FFF : 16'hFFFF)) begin
            n_bad++; $display("FAIL reset_mode inst%0d got %h", k, mode_o[k]);
         end
      end
      reset_n = 1'b1;
      idle();
   endtask

   task automatic test_sr_legacy();
      bit [3:0] exp_q, exp_qb, exp_chg;
      bit [1:0] ab [4];
      ab[0] = 2'b10; ab[1] = 2'b11; ab[2] = 2'b00; ab[3] = 2'b01;
      exp_q = 4'b0001; exp_qb = 4'b1000; exp_chg = 4'b0011;
      en = 8'h01;
      for (int s = 0; s < 4; s++) begin
         in_a = {7'd0, ab[s][1]}; in_b = {7'd0, ab[s][0]};
         tick();
         for (int k = 0; k < 5; k++) begin
            n_cmp++;
            if (act_vec(k) !== exp_vec(k)) begin
               n_bad++; $display("FAIL sr_legacy_model step%0d inst%0d got %h exp %h", s, k, act_vec(k), exp_vec(k));
            end
         end
         n_cmp++;
         if ({q_o[0][0], qb_o[0][0], chg_o[0][0]} !== {exp_q[s], exp_qb[s], exp_chg[s]}) begin
            n_bad++; $display("FAIL sr_legacy step%0d got q,qb,chg=%b%b%b exp %b%b%b", s, q_o[0][0], qb_o[0][0], chg_o[0][0], exp_q[s], exp_qb[s], exp_chg[s]);
         end
         if (s > 0) begin
            n_cmp++;
            if (err_o[0][0] !== 1'b1) begin
               n_bad++; $display("FAIL sr_legacy_err step%0d got %b exp 1", s, err_o[0][0]);
            end
         end
      end
      idle();
   endtask

   task automatic test_policy_sweep();
      bit exp_q [4];
      bit exp_qb [4];
      exp_q[0] = 0; exp_q[1] = 0; exp_q[2] = 1; exp_q[3] = 0;
      exp_qb[0] = 0; exp_qb[1] = 1; exp_qb[2] = 0; exp_qb[3] = 1;
      err_clr = 8'h01;
      tick();
      for (int k = 0; k < 5; k++) begin
         n_cmp++;
         if ({err_o[k][0], q_o[k][0], qb_o[k][0]} !== 3'b001) begin
            n_bad++; $display("FAIL policy_prep inst%0d got err,q,qb=%b%b%b exp 001", k, err_o[k][0], q_o[k][0], qb_o[k][0]);
         end
      end
      err_clr = '0; en = 8'h01; in_a = 8'h01; in_b = 8'h01;
      tick();
      for (int k = 0; k < 5; k++) begin
         n_cmp++;
         if ({q_o[k][0], qb_o[k][0], err_o[k][0]} !== {exp_q[pol(k)], exp_qb[pol(k)], 1'b1}) begin
            n_bad++; $display("FAIL policy_sweep inst%0d got q,qb,err=%b%b%b exp %b%b1", k, q_o[k][0], qb_o[k][0], err_o[k][0], exp_q[pol(k)], exp_qb[pol(k)]);
         end
         n_cmp++;
         if (act_vec(k) !== exp_vec(k)) begin
            n_bad++; $display("FAIL policy_model inst%0d got %h exp %h", k, act_vec(k), exp_vec(k));
         end
      end
      idle();
   endtask

   task automatic test_mode_race();
      en = 8'h04; in_b = 8'h04;
      tick();
      cfg_we = 1'b1; cfg_ch = 3'd2; cfg_mode = 2'd1; in_a = 8'h04; in_b = 8'h00;
      tick();
      for (int k = 0; k < 5; k++) begin
         n_cmp++;
         if ({q_o[k][2], mode_o[k][5:4]} !== 3'b1_01) begin
            n_bad++; $display("FAIL mode_race_old inst%0d got q2=%b mode2=%0d exp q2=1 mode2=1", k, q_o[k][2], mode_o[k][5:4]);
         end
      end
      cfg_we = 1'b0;
      tick();
      for (int k = 0; k < 5; k++) begin
         n_cmp++;
         if ({q_o[k][2], qb_o[k][2], chg_o[k][2]} !== 3'b011) begin
            n_bad++; $display("FAIL mode_race_new inst%0d got q,qb,chg=%b%b%b exp 011", k, q_o[k][2], qb_o[k][2], chg_o[k][2]);
         end
      end
      idle();
      cfg_we = 1'b1; cfg_mode = 2'd0;
      for (int c = 6; c < 8; c++) begin
         cfg_ch = 3'(c);
         tick();
         n_cmp++;
         if (mode_o[4] !== 16'h0FDF) begin
            n_bad++; $display("FAIL cfg_out_of_range ch%0d got %h exp 0fdf", c, mode_o[4]);
         end
         for (int k = 0; k < 5; k++) begin
            n_cmp++;
            if (act_vec(k) !== exp_vec(k)) begin
               n_bad++; $display("FAIL cfg_model ch%0d inst%0d got %h exp %h", c, k, act_vec(k), exp_vec(k));
            end
         end
      end
      idle();
   endtask

   task automatic test_jk_d_enable();
      bit [1:0] md [3];
      md[0] = 2'd2; md[1] = 2'd0; md[2] = 2'd1;
      cfg_we = 1'b1;
      for (int c = 0; c < 3; c++) begin
         cfg_ch = 3'(c + 3); cfg_mode = md[c];
         tick();
      end
      cfg_we = 1'b0;
      repeat (3) begin
         in_a = 8'($urandom) | 8'h38; in_b = 8'($urandom) | 8'h08;
         tick();
         for (int k = 0; k < 5; k++) begin
            n_cmp++;
            if (chg_o[k] !== 8'h00 || act_vec(k) !== exp_vec(k)) begin
               n_bad++; $display("FAIL en_hold inst%0d got %h exp %h", k, act_vec(k), exp_vec(k));
            end
         end
      end
      en = 8'h38;
      for (int s = 0; s < 2; s++) begin
         in_a = 8'h28 | (8'($urandom) & 8'h10); in_b = 8'h08;
         tick();
         for (int k = 0; k < 5; k++) begin
            n_cmp++;
            if ({q_o[k][3], chg_o[k][3], q_o[k][4]} !== {(s == 0), 1'b1, in_a[4]}) begin
               n_bad++; $display("FAIL jk_d step%0d inst%0d got q3,chg3,q4=%b%b%b exp %b1%b", s, k, q_o[k][3], chg_o[k][3], q_o[k][4], (s == 0), in_a[4]);
            end
            n_cmp++;
            if (act_vec(k) !== exp_vec(k)) begin
               n_bad++; $display("FAIL jk_d_model step%0d inst%0d got %h exp %h", s, k, act_vec(k), exp_vec(k));
            end
         end
      end
      idle();
   endtask

   task automatic test_err_clr();
      en = 8'h01; in_a = 8'h01; in_b = 8'h01; err_clr = 8'h01;
      tick();
      for (int k = 0; k < 5; k++) begin
         n_cmp++;
         if (err_o[k][0] !== 1'b1) begin
            n_bad++; $display("FAIL err_set_wins inst%0d got %b exp 1", k, err_o[k][0]);
         end
      end
      in_a = '0; in_b = '0;
      tick();
      for (int k = 0; k < 5; k++) begin
         n_cmp++;
         if (err_o[k][0] !== 1'b0) begin
            n_bad++; $display("FAIL err_clear inst%0d got %b exp 0", k, err_o[k][0]);
         end
      end
      reset_n = 1'b0; en = 8'hFF; in_a = 8'hFF; in_b = 8'hFF;
      cfg_we = 1'b1; cfg_ch = 3'd0; cfg_mode = 2'd0; err_clr = '0;
      tick();
      for (int k = 0; k < 5; k++) begin
         n_cmp++;
         if ({q_o[k], qb_o[k], err_o[k], chg_o[k], mode_o[k]} !==
             {8'h00, (k == 4) ? 8'h3F : 8'hFF, 16'h0000, (k == 4) ? 16'h0FFF : 16'hFFFF}) begin
            n_bad++; $display("FAIL mid_reset inst%0d got %h", k, act_vec(k));
         end
      end
      reset_n = 1'b1;
      idle();
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         rand_inputs();
         if ($urandom_range(0, 3) != 0) err_clr = '0;
         reset_n = ($urandom_range(0, 60) != 0);
         tick();
         for (int k = 0; k < 5; k++) begin
            n_cmp++;
            if (act_vec(k) !== exp_vec(k)) begin
               n_bad++; $display("FAIL random cyc%0d inst%0d got %h exp %h", n, k, act_vec(k), exp_vec(k));
            end
         end
      end
      reset_n = 1'b1;
      idle();
   endtask

   initial begin
      reset_n = 1'b0;
      idle();
      test_reset();
      test_sr_legacy();
      test_policy_sweep();
      test_mode_race();
      test_jk_d_enable();
      test_err_clr();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
